ones_counter_63: RTL and testbench

// - Population counter: counts the '1' bits in a 63-bit input word and reports the count on a 6-bit output.
// - 63 = 2^6-1, so the 6-bit result never overflows (max 63).
// - Built as a full-adder compression tree with a registered output.
// - Sits as a leaf datapath block; consumers sample S one clock after presenting I.
//

---
 rtl/ones_counter_63_pkg.sv | 7 +
 rtl/ones_counter_63_full_adder_1b.sv | 13 +
 rtl/ones_counter_63.sv | 56 +++++
 tb/tb_ones_counter_63.sv | 104 ++++++++++
 4 files changed

// File: rtl/ones_counter_63_pkg.sv
// Shared widths for the 63-bit population counter.
package ones_counter_63_pkg;

  localparam int IN_W  = 63;
  localparam int OUT_W = 6;

endpackage

// File: rtl/ones_counter_63_full_adder_1b.sv
// Single-bit full adder, the only arithmetic cell of the population-count tree.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ones_counter_63.sv
// 63-bit population counter: recursive full-adder tree over 2^k-1 inputs, registered 6-bit result.
module ones_counter_63
  import ones_counter_63_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  I,
  output logic [OUT_W-1:0] S
);

  // Node j of level k owns the virtual slot [j*2^k, (j+1)*2^k) of I; its two children use
  // the lower 2^(k-1)-1 positions of each half-slot and the top bit of the lower half is the
  // spare carry-in. This maps every bit of I to exactly one leaf or spare.
  for (genvar k = 1; k <= OUT_W; k++) begin : g_lvl
    for (genvar j = 0; j < (32'sd1 <<< (OUT_W - k)); j++) begin : g_node
      logic [k-1:0] cnt_s;

      if (k == 1) begin : g_leaf
        assign cnt_s = I[2*j];
      end else begin : g_sum
        localparam int SPARE = j * (2 ** k) + (2 ** (k - 1)) - 1;

        for (genvar i = 0; i < k - 1; i++) begin : g_bit
          logic carry_in_s;
          logic cout_s;

          if (i == 0) begin : g_cin_spare
            assign carry_in_s = I[SPARE];
          end else begin : g_cin_chain
            assign carry_in_s = g_bit[i-1].cout_s;
          end

          full_adder_1b u_fa (
            .a    (g_lvl[k-1].g_node[2*j].cnt_s[i]),
            .b    (g_lvl[k-1].g_node[2*j+1].cnt_s[i]),
            .cin  (carry_in_s),
            .sum  (cnt_s[i]),
            .cout (cout_s)
          );
        end

        assign cnt_s[k-1] = g_bit[k-2].cout_s;
      end
    end
  end

  // Output register: async clear, otherwise capture the tree root every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S <= 6'd0;
    end else begin
      S <= g_lvl[OUT_W].g_node[0].cnt_s;
    end
  end

endmodule

// File: tb/tb_ones_counter_63.sv
// Directed + random bench for ones_counter_63 with a queue-based scoreboard of expected counts.
module tb_ones_counter_63;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [62:0] I   = 63'd0;
  logic [5:0]  S;

  int passed = 0;
  int total  = 0;
  logic [5:0] exp_q[$];

  localparam logic [62:0] ALL_ONES = 63'h7FFF_FFFF_FFFF_FFFF;

  ones_counter_63 dut (
    .clk (clk),
    .rst (rst),
    .I   (I),
    .S   (S)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [5:0] obs, input logic [5:0] exp, input string tag);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive v on the falling edge, queue its expected count, compare one rising edge later.
  task automatic step(input logic [62:0] v, input logic [5:0] exp, input string tag);
    logic [5:0] e;
    @(negedge clk);
    I = v;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(S, e, tag);
  endtask

  initial begin
    logic [62:0] v;

    // Reset with all ones on the input: output must be cleared without any clock edge.
    rst = 1'b1;
    I   = ALL_ONES;
    #1;
    check(S, 6'd0, "reset_async");
    repeat (2) @(posedge clk);
    #1;
    check(S, 6'd0, "reset_held");
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(6'd63);
    @(posedge clk);
    #1;
    check(S, exp_q.pop_front(), "reset_release");

    step(63'h0000_0000_0000_0001, 6'd1, "single_one");
    step(63'h71,                  6'd4, "hex_71");
    step(63'hF71,                 6'd8, "hex_f71");
    step(ALL_ONES,                6'd63, "all_ones");
    step(63'd0,                   6'd0, "all_zero");

    for (int i = 0; i < 63; i++) begin
      v = 63'd1 << i;
      step(v, 6'd1, "walk_one");
    end
    for (int i = 0; i < 63; i++) begin
      v = ALL_ONES ^ (63'd1 << i);
      step(v, 6'd62, "walk_zero");
    end

    for (int n = 0; n < 1000; n++) begin
      v = {$urandom(), $urandom()};
      if (n % 7 == 3) v = v & {$urandom(), $urandom()};
      if (n % 11 == 5) v = v | {$urandom(), $urandom()};
      step(v, 6'($countones(v)), "random");
    end

    // Mid-stream reset between edges, then recovery on the first edge after release.
    step(ALL_ONES, 6'd63, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    check(S, 6'd0, "mid_reset_async");
    @(posedge clk);
    #1;
    check(S, 6'd0, "mid_reset_edge");
    @(negedge clk);
    rst = 1'b0;
    I   = 63'hF71;
    exp_q.push_back(6'd8);
    @(posedge clk);
    #1;
    check(S, exp_q.pop_front(), "mid_reset_resume");
    step(63'h5555_5555_5555_5555, 6'd32, "alt_pattern");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
